frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/apu_pkg.sv | 18 +
 rtl/frame_divider.sv | 32 +++
 rtl/frame_sequencer.sv | 118 +++++++++++
 tb/tb_frame_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-counter mode encoding, step counts and the
// default divider length used by the frame sequencer.
package apu_pkg;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

    localparam int unsigned STEPS_4STEP         = 4;
    localparam int unsigned STEPS_5STEP         = 5;
    localparam int unsigned STEP_CYCLES_DEFAULT = 3729;

    function automatic logic [2:0] last_step(input mode_e mode);
        return (mode == MODE_5STEP) ? 3'(STEPS_5STEP - 1) : 3'(STEPS_4STEP - 1);
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Step-length divider: counts 0..STEP_CYCLES-1, flags the terminal count and
// restarts from zero on a synchronous clear.
module frame_divider
    import apu_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic        apu_clk,
    input  logic        rst_n,
    input  logic        i_clr,
    output logic [14:0] o_count,
    output logic        o_wrap
);

    localparam logic [14:0] LAST = 15'(STEP_CYCLES - 1);

    logic [14:0] r_count;

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || o_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 15'd1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = (r_count == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer: quarter/half-frame strobes and frame IRQ.
// Define FRAME_IRQ_EN to build the frame interrupt flag; otherwise frame_irq is 0.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic       apu_clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [7:0] cfg_data,
    input  logic       irq_ack,
    output logic       qtr_clk,
    output logic       hlf_clk,
    output logic       frame_irq
);

    mode_e       r_mode;
    mode_e       w_mode_nxt;
    logic [2:0]  r_step;
    logic [2:0]  w_step_nxt;
    logic        w_qtr_nxt;
    logic        w_hlf_nxt;
    logic        w_irq_evt;
    logic        w_wrap;
    logic [14:0] w_div_count;

    frame_divider #(.STEP_CYCLES(STEP_CYCLES)) u_div (
        .apu_clk (apu_clk),
        .rst_n   (rst_n),
        .i_clr   (cfg_we),
        .o_count (w_div_count),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_4STEP;
            r_step  <= '0;
            qtr_clk <= 1'b0;
            hlf_clk <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_step  <= w_step_nxt;
            qtr_clk <= w_qtr_nxt;
            hlf_clk <= w_hlf_nxt;
        end
    end

    // A register write restarts the frame and swallows any coincident wrap.
    always_comb begin
        w_mode_nxt = r_mode;
        w_step_nxt = r_step;
        w_qtr_nxt  = 1'b0;
        w_hlf_nxt  = 1'b0;
        w_irq_evt  = 1'b0;
        if (cfg_we) begin
            w_mode_nxt = mode_e'(cfg_data[7]);
            w_step_nxt = '0;
            w_qtr_nxt  = cfg_data[7];
            w_hlf_nxt  = cfg_data[7];
        end else if (w_wrap) begin
            case (r_step)
                3'd0: w_qtr_nxt = 1'b1;
                3'd1: begin
                    w_qtr_nxt = 1'b1;
                    w_hlf_nxt = 1'b1;
                end
                3'd2: w_qtr_nxt = 1'b1;
                3'd3: begin
                    if (r_mode == MODE_4STEP) begin
                        w_qtr_nxt = 1'b1;
                        w_hlf_nxt = 1'b1;
                        w_irq_evt = 1'b1;
                    end
                end
                3'd4: begin
                    w_qtr_nxt = 1'b1;
                    w_hlf_nxt = 1'b1;
                end
                default: ;
            endcase
            w_step_nxt = (r_step == last_step(r_mode)) ? '0 : r_step + 3'd1;
        end
    end

`ifdef FRAME_IRQ_EN
    logic r_irq_inh;
    logic r_irq;
    logic w_unused;

    // Setting wins over any coincident clear.
    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_inh <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_irq_inh <= cfg_data[6];
            end
            if (w_irq_evt && !r_irq_inh) begin
                r_irq <= 1'b1;
            end else if (irq_ack || (cfg_we && cfg_data[6])) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign frame_irq = r_irq;
    assign w_unused  = ^{w_div_count, cfg_data[5:0]};
`else
    logic w_unused;

    assign frame_irq = 1'b0;
    assign w_unused  = ^{w_div_count, cfg_data[6:0], irq_ack, w_irq_evt};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with STEP_CYCLES=4; IRQ expectations
// follow FRAME_IRQ_EN.
module tb_frame_sequencer;

    localparam int unsigned SC = 4;

    logic       apu_clk  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       cfg_we   = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       irq_ack  = 1'b0;
    logic       qtr_clk;
    logic       hlf_clk;
    logic       frame_irq;

    int   checks  = 0;
    int   passes  = 0;
    int   c       = 0;
    logic mode5   = 1'b0;
    logic inh     = 1'b0;
    logic irq_exp = 1'b0;

    always #5 apu_clk = ~apu_clk;

    frame_sequencer #(.STEP_CYCLES(SC)) dut (
        .apu_clk   (apu_clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .irq_ack   (irq_ack),
        .qtr_clk   (qtr_clk),
        .hlf_clk   (hlf_clk),
        .frame_irq (frame_irq)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed qtr/hlf/irq=%b expected %b", tag, obs, exp);
    endtask

    // Expected {qtr,hlf} c cycles after the frame was aligned (divider=0, step=0).
    function automatic logic [1:0] strobes(input int cyc, input logic m5);
        int p;
        if (m5) begin
            p = cyc % 20;
            return {(p == 4 || p == 8 || p == 12 || p == 0), (p == 8 || p == 0)};
        end
        return {(cyc % 4 == 0), (cyc % 8 == 0)};
    endfunction

    task automatic cyc(input logic ack, input string tag);
        logic [1:0] s;
        irq_ack = ack;
        @(posedge apu_clk);
        #1;
        irq_ack = 1'b0;
        c++;
        s = strobes(c, mode5);
`ifdef FRAME_IRQ_EN
        if (!mode5 && (c % 16 == 0) && !inh) irq_exp = 1'b1;
        else if (ack) irq_exp = 1'b0;
`endif
        check($sformatf("%s c=%0d", tag, c), {qtr_clk, hlf_clk, frame_irq}, {s, irq_exp});
    endtask

    task automatic cfg(input logic [7:0] d, input string tag);
        cfg_we   = 1'b1;
        cfg_data = d;
        @(posedge apu_clk);
        #1;
        cfg_we   = 1'b0;
        cfg_data = '0;
        c        = 0;
        mode5    = d[7];
        inh      = d[6];
`ifdef FRAME_IRQ_EN
        if (d[6]) irq_exp = 1'b0;
`endif
        check(tag, {qtr_clk, hlf_clk, frame_irq}, {d[7], d[7], irq_exp});
    endtask

    initial begin
        repeat (2) @(posedge apu_clk);
        #1;
        check("reset", {qtr_clk, hlf_clk, frame_irq}, 3'b000);
        rst_n = 1'b1;
        c     = 0;

        repeat (16) cyc(1'b0, "4step");
        cyc(1'b0, "irq_hold");
        cyc(1'b1, "irq_ack");
        repeat (13) cyc(1'b0, "4step_b");
        cyc(1'b1, "ack_vs_set");

        cfg(8'h40, "cfg40");
        repeat (32) cyc(1'b0, "inhibit");

        cfg(8'h80, "cfg80");
        repeat (20) cyc(1'b0, "5step");

        repeat (3) cyc(1'b0, "pre_wrap");
        cfg(8'h00, "cfg_on_wrap");
        repeat (4) cyc(1'b0, "after_wrap");

        cfg(8'hC0, "cfgC0");
        repeat (2) cyc(1'b0, "pre_rst");
        rst_n = 1'b0;
        #1;
        check("rst_async", {qtr_clk, hlf_clk, frame_irq}, 3'b000);
        @(posedge apu_clk);
        #1;
        check("rst_hold", {qtr_clk, hlf_clk, frame_irq}, 3'b000);
        rst_n   = 1'b1;
        c       = 0;
        mode5   = 1'b0;
        inh     = 1'b0;
        irq_exp = 1'b0;
        repeat (16) cyc(1'b0, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
